// File: rtl/largest_lane_encoder.sv
// Picks the lane with the most waiting cars from four per-lane counts.
// The result is then held for at least MIN_HOLD cycles and until it has been acknowledged.
module largest_lane_encoder #(
  parameter int CNT_W    = 4,
  parameter int MIN_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_n,
  input  logic [CNT_W-1:0] cnt_e,
  input  logic [CNT_W-1:0] cnt_s,
  input  logic [CNT_W-1:0] cnt_w,
  input  logic             sample,
  input  logic             ack,
  output logic [1:0]       largest,
  output logic             valid,
  output logic             none,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CMP1, CMP2, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, e_q, s_q, w_q;
  logic [CNT_W-1:0] v_ne_q, v_sw_q;
  logic             idx_ne_q, idx_sw_q;
  logic [1:0]       largest_q;
  logic             valid_q, none_q, ack_seen_q;
  logic [7:0]       hold_q;

  // Final stage: the S/W pair must be strictly larger to win, so ties keep the lower index.
  logic             win_sw;
  logic [1:0]       win_idx;
  logic [CNT_W-1:0] win_val;
  logic             all_zero;
  logic             hold_done;

  assign win_sw    = (v_sw_q > v_ne_q);
  assign win_idx   = win_sw ? {1'b1, idx_sw_q} : {1'b0, idx_ne_q};
  assign win_val   = win_sw ? v_sw_q : v_ne_q;
  assign all_zero  = (win_val == '0);
  assign hold_done = ack_seen_q && (hold_q == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (sample) state_d = CMP1;
      CMP1: state_d = CMP2;
      CMP2: state_d = all_zero ? IDLE : HOLD;
      HOLD: if (hold_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    largest = largest_q;
    valid   = valid_q;
    none    = none_q;
    busy    = (state_q != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q        <= '0;
      e_q        <= '0;
      s_q        <= '0;
      w_q        <= '0;
      v_ne_q     <= '0;
      v_sw_q     <= '0;
      idx_ne_q   <= 1'b0;
      idx_sw_q   <= 1'b0;
      largest_q  <= 2'b00;
      valid_q    <= 1'b0;
      none_q     <= 1'b0;
      ack_seen_q <= 1'b0;
      hold_q     <= 8'd0;
    end else begin
      none_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample) begin
            n_q <= cnt_n;
            e_q <= cnt_e;
            s_q <= cnt_s;
            w_q <= cnt_w;
          end
        end
        CMP1: begin
          idx_ne_q <= (e_q > n_q);
          v_ne_q   <= (e_q > n_q) ? e_q : n_q;
          idx_sw_q <= (w_q > s_q);
          v_sw_q   <= (w_q > s_q) ? w_q : s_q;
        end
        CMP2: begin
          if (all_zero) begin
            none_q <= 1'b1;
          end else begin
            largest_q <= win_idx;
            valid_q   <= 1'b1;
            hold_q    <= 8'(MIN_HOLD - 1);
          end
        end
        HOLD: begin
          if (hold_q != 8'd0) hold_q <= hold_q - 8'd1;
          if (valid_q && ack) begin
            valid_q    <= 1'b0;
            ack_seen_q <= 1'b1;
          end
          if (hold_done) ack_seen_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_largest_lane_encoder.sv
// Scoreboard bench for largest_lane_encoder: expected results queue at sample time
// and are compared when valid rises or none pulses.
module tb_largest_lane_encoder;

  localparam int CNT_W    = 4;
  localparam int MIN_HOLD = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] cnt_n, cnt_e, cnt_s, cnt_w;
  logic             sample, ack;
  logic [1:0]       largest;
  logic             valid, none, busy;

  largest_lane_encoder #(.CNT_W(CNT_W), .MIN_HOLD(MIN_HOLD)) dut (
    .clk(clk), .rst(rst),
    .cnt_n(cnt_n), .cnt_e(cnt_e), .cnt_s(cnt_s), .cnt_w(cnt_w),
    .sample(sample), .ack(ack),
    .largest(largest), .valid(valid), .none(none), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       zero;
    logic [1:0] lane;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic [1:0] model_largest = 2'b00;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: scan lanes N,E,S,W and keep the first strict maximum.
  function automatic logic [1:0] ref_lane(input logic [CNT_W-1:0] n, e, s, w);
    logic [CNT_W-1:0] c [4];
    logic [CNT_W-1:0] best;
    logic [1:0]       idx;
    c[0] = n; c[1] = e; c[2] = s; c[3] = w;
    best = c[0];
    idx  = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (c[i] > best) begin
        best = c[i];
        idx  = 2'(i);
      end
    end
    return idx;
  endfunction

  // Scoreboard consumer.
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      valid_prev = 1'b0;
    end else begin
      if (valid && !valid_prev) begin
        check_eq("sb_pending_valid", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_eq("sb_zero_flag_valid", int'(e.zero), 0);
          check_eq("sb_largest", int'(largest), int'(e.lane));
        end
      end
      if (none) begin
        check_eq("sb_pending_none", int'(sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check_eq("sb_zero_flag_none", int'(e.zero), 1);
          check_eq("sb_largest_kept", int'(largest), int'(e.lane));
        end
      end
      valid_prev = valid;
    end
  end

  task automatic run_eval(input logic [CNT_W-1:0] n, e, s, w,
                          input int ack_delay, input bit hold_sample);
    exp_t       ex;
    logic [1:0] lane;
    bit         zero;
    int         cyc;
    int         exp_cyc;
    zero = (n == 0) && (e == 0) && (s == 0) && (w == 0);
    lane = ref_lane(n, e, s, w);
    if (!zero) model_largest = lane;
    ex.zero = zero;
    ex.lane = model_largest;
    sb_q.push_back(ex);
    cnt_n = n; cnt_e = e; cnt_s = s; cnt_w = w;
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    check_eq("busy_after_capture", int'(busy), 1);
    // Scramble inputs after capture; result must not change.
    cnt_n = CNT_W'($urandom_range(0, 15));
    cnt_e = CNT_W'($urandom_range(0, 15));
    cnt_s = CNT_W'($urandom_range(0, 15));
    cnt_w = CNT_W'($urandom_range(0, 15));
    @(posedge clk); #1;
    check_eq("valid_early", int'(valid), 0);
    @(posedge clk); #1;
    if (zero) begin
      check_eq("zero_valid", int'(valid), 0);
      check_eq("zero_none", int'(none), 1);
      check_eq("zero_idle", int'(busy), 0);
      check_eq("zero_largest", int'(largest), int'(model_largest));
      @(posedge clk); #1;
      check_eq("none_one_cycle", int'(none), 0);
      return;
    end
    check_eq("valid_at_t2", int'(valid), 1);
    check_eq("largest_at_t2", int'(largest), int'(lane));
    repeat (ack_delay) begin
      @(posedge clk); #1;
    end
    check_eq("valid_before_ack", int'(valid), 1);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check_eq("valid_after_ack", int'(valid), 0);
    check_eq("busy_after_ack", int'(busy), 1);
    if (hold_sample) sample = 1'b1;
    cyc = 0;
    while (busy && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2) sample = 1'b0;
    end
    sample = 1'b0;
    exp_cyc = (7 - ack_delay > 1) ? 7 - ack_delay : 1;
    check_eq("hold_exit_cycles", cyc, exp_cyc);
    check_eq("largest_retained", int'(largest), int'(lane));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sample = 1'b0; ack = 1'b0;
    cnt_n = '0; cnt_e = '0; cnt_s = '0; cnt_w = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_largest", int'(largest), 0);
    check_eq("rst_valid", int'(valid), 0);
    check_eq("rst_none", int'(none), 0);
    check_eq("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_eval(4'd3, 4'd9, 4'd5, 4'd2, 0, 1'b1);
    run_eval(4'd7, 4'd7, 4'd7, 4'd7, 2, 1'b0);
    run_eval(4'd0, 4'd4, 4'd0, 4'd4, 1, 1'b0);
    run_eval(4'd1, 4'd2, 4'd6, 4'd3, 0, 1'b0);
    run_eval(4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b0);
    run_eval(4'd14, 4'd14, 4'd14, 4'd15, 20, 1'b0);

    // Reset while in CMP2 aborts the evaluation.
    cnt_n = 4'd5; cnt_e = 4'd1; cnt_s = 4'd1; cnt_w = 4'd1;
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_largest", int'(largest), 0);
    check_eq("midrst_valid", int'(valid), 0);
    check_eq("midrst_none", int'(none), 0);
    check_eq("midrst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_largest = 2'b00;
    repeat (5) @(posedge clk);
    #1;
    check_eq("midrst_no_valid", int'(valid), 0);
    run_eval(4'd2, 4'd3, 4'd11, 4'd4, 3, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_eval(CNT_W'($urandom_range(0, 15)), CNT_W'($urandom_range(0, 15)),
               CNT_W'($urandom_range(0, 15)), CNT_W'($urandom_range(0, 15)),
               int'($urandom_range(0, 10)), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/largest_lane_encoder.md
LARGEST_LANE_ENCODER -- requirements
Module: largest_lane_encoder

Interface
REQ-001 Parameter CNT_W, default 4, SHALL set the width of each per-lane car count.
REQ-002 Parameter MIN_HOLD, default 8, SHALL set the minimum cycles a result is held before a new sample is accepted (legal range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 cnt_n, cnt_e, cnt_s, cnt_w  input  CNT_W each  SHALL be the unsigned car counts for lanes N, E, S, W.
REQ-006 sample  input  1  SHALL request a new evaluation when high in IDLE.
REQ-007 ack  input  1  SHALL acknowledge the presented result.
REQ-008 largest  output  2  SHALL be the encoded winning lane: 00=N, 01=E, 10=S, 11=W.
REQ-009 valid  output  1  SHALL flag that largest holds an unacknowledged new result.
REQ-010 none  output  1  SHALL pulse for one cycle when an evaluation found all counts zero.
REQ-011 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, CMP1, CMP2 and HOLD.
REQ-013 In IDLE with sample=1, the block SHALL register all four counts and go to CMP1 at that edge.
REQ-014 In CMP1, it SHALL compare N vs E and S vs W, register each pair's winner index and value, and go to CMP2.
REQ-015 In CMP2, it SHALL compare the two pair winners and register the overall winner index.
REQ-016 All comparisons SHALL be unsigned, CNT_W bits wide, with no overflow or saturation.
REQ-017 On ties, the lower lane index SHALL win (priority N > E > S > W), at every stage.
REQ-018 Latency: with capture on edge t0, largest SHALL update and valid SHALL rise on edge t0+2.
REQ-019 If all captured counts are zero, CMP2 SHALL leave largest unchanged, keep valid=0, pulse none for one cycle and return to IDLE.
REQ-020 On entry to HOLD, the hold counter SHALL load MIN_HOLD-1 and decrement once per cycle in HOLD, stopping at 0.
REQ-021 ack sampled high while valid=1 SHALL clear valid on that edge and set an internal ack_seen flag.
REQ-022 ack SHALL be honoured in the first cycle valid is high.
REQ-023 ack while valid=0 SHALL be ignored.
REQ-024 HOLD SHALL exit to IDLE on the edge where ack_seen=1 and the counter is 0; ack_seen SHALL clear on exit.
REQ-025 sample SHALL be ignored, not queued, in CMP1, CMP2 and HOLD.
REQ-026 A sample in the first IDLE cycle after HOLD SHALL be accepted.
REQ-027 largest SHALL retain its last value in all states until the next non-zero evaluation.
REQ-028 Input counts SHALL be read only at the capture edge; changes afterwards SHALL NOT affect the result.

Reset
REQ-029 While rst=1, state SHALL be IDLE, and largest=00, valid=0, none=0 and busy=0.
REQ-030 While rst=1, the hold counter, ack_seen and all captured and intermediate registers SHALL be 0.
REQ-031 Reset asserted in any state SHALL abort the evaluation immediately, with no result presented.

Verification
REQ-032 Winner: counts N=3, E=9, S=5, W=2, sample pulse -> largest=01 and valid=1 two edges after capture; busy=1 from the capture edge.
REQ-033 Ties: N=7, E=7, S=7, W=7 -> largest=00; N=0, E=4, S=0, W=4 -> largest=01.
REQ-034 All zero: all counts 0 with prior largest=10 -> none pulses for 1 cycle, valid stays 0, largest stays 10, back in IDLE after CMP2.
REQ-035 Hold timing (MIN_HOLD=8): ack in first valid cycle -> valid drops next edge, IDLE only after 8 HOLD cycles, and a sample during HOLD is ignored; with ack delayed 20 cycles, IDLE follows the ack edge.
REQ-036 Full scale (CNT_W=4): W=15, others 14 -> largest=11; counts changed after capture -> result unaffected.
REQ-037 Reset mid-operation: rst asserted in CMP2 -> outputs immediately 00/0/0/0, no valid ever appears, and the next sample evaluates normally.
